mmu_rsp_merger: RTL and testbench

Downstream stage of mmu_top. It drains the alloc and free response FIFOs through their pop / not_empty interface, using round-robin arbitration. It merges both streams into one tagged valid/ready response channel toward the host interface and keeps saturating success/fail statistics. It hides the mmu_top rule that data appears one cycle after the pop.

---
 rtl/mmu_rsp_merger_pkg.sv | 17 +
 rtl/rsp_showahead_fifo.sv | 48 ++++
 rtl/mmu_rsp_merger.sv | 123 ++++++++++++
 tb/tb_mmu_rsp_merger.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_rsp_merger_pkg.sv
// Shared widths and types for the MMU response merger.
package mmu_rsp_merger_pkg;
  localparam int REQ_ID_WIDTH       = 13;
  localparam int ALL_PAGE_IDX_WIDTH = 15;
  localparam int FAIL_REASON_WIDTH  = 3;
  localparam int FIFO_OUT_DEPTH     = 4;
  localparam int FIFO_STAT_WIDTH    = 16;

  typedef enum logic {
    SRC_ALLOC = 1'b0,
    SRC_FREE  = 1'b1
  } src_e;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_ALLOC) ? SRC_FREE : SRC_ALLOC;
  endfunction
endpackage

// File: rtl/rsp_showahead_fifo.sv
// Show-ahead FIFO: head entry is always visible on rd_data, valid and count are registered.
// Write lands one edge later; a simultaneous read and write keeps count unchanged.
module rsp_showahead_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          valid
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_wr, do_rd;
  logic [CW-1:0] count_nxt;

  always_comb begin
    do_rd     = rd_en && valid;
    do_wr     = wr_en && ((count != CW'(DEPTH)) || do_rd);
    count_nxt = count + CW'(do_wr) - CW'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      valid <= (count_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/mmu_rsp_merger.sv
// Merges alloc/free response FIFOs into one tagged valid/ready stream with round-robin pops.
// Pop-to-rsp_valid is 2 cycles; pops are credit-gated so a low rsp_ready only stalls, never drops.
module mmu_rsp_merger
  import mmu_rsp_merger_pkg::*;
#(
  parameter int ID_W       = REQ_ID_WIDTH,
  parameter int PAGE_IDX_W = ALL_PAGE_IDX_WIDTH,
  parameter int REASON_W   = FAIL_REASON_WIDTH,
  parameter int OUT_DEPTH  = FIFO_OUT_DEPTH,
  parameter int STAT_W     = FIFO_STAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_rsp_fifo_not_empty,
  output logic                  alloc_rsp_pop,
  input  logic [ID_W-1:0]       alloc_rsp_id,
  input  logic [PAGE_IDX_W-1:0] alloc_rsp_page_idx,
  input  logic                  alloc_rsp_fail,
  input  logic [REASON_W-1:0]   alloc_rsp_fail_reason,
  input  logic                  free_rsp_fifo_not_empty,
  output logic                  free_rsp_pop,
  input  logic [ID_W-1:0]       free_rsp_id,
  input  logic                  free_rsp_fail,
  input  logic [REASON_W-1:0]   free_rsp_fail_reason,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_is_free,
  output logic [ID_W-1:0]       rsp_id,
  output logic [PAGE_IDX_W-1:0] rsp_page_idx,
  output logic                  rsp_fail,
  output logic [REASON_W-1:0]   rsp_fail_reason,
  output logic [STAT_W-1:0]     stat_alloc_ok,
  output logic [STAT_W-1:0]     stat_alloc_fail,
  output logic [STAT_W-1:0]     stat_free_ok,
  output logic [STAT_W-1:0]     stat_free_fail
);
  localparam int ENT_W = 2 + ID_W + PAGE_IDX_W + REASON_W;
  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic             cap_valid;
  src_e             cap_src;
  src_e             rr;
  logic             alloc_elig, free_elig, credit_ok;
  logic             pop_alloc, pop_free;
  logic [CNT_W-1:0] buf_count;
  logic             cap_is_free, cap_fail;
  logic [ENT_W-1:0] wr_data, head;

  always_comb begin
    alloc_elig = alloc_rsp_fifo_not_empty && !(cap_valid && cap_src == SRC_ALLOC);
    free_elig  = free_rsp_fifo_not_empty && !(cap_valid && cap_src == SRC_FREE);
    // The pop in flight already owns a slot: it lands in the buffer at the next edge.
    credit_ok  = rst_n && ((buf_count + CNT_W'(cap_valid)) < CNT_W'(OUT_DEPTH));
    pop_alloc  = 1'b0;
    pop_free   = 1'b0;
    if (credit_ok) begin
      if (alloc_elig && free_elig) begin
        pop_alloc = (rr == SRC_ALLOC);
        pop_free  = (rr == SRC_FREE);
      end else begin
        pop_alloc = alloc_elig;
        pop_free  = free_elig;
      end
    end
  end

  assign alloc_rsp_pop = pop_alloc;
  assign free_rsp_pop  = pop_free;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_src   <= SRC_ALLOC;
      rr        <= SRC_ALLOC;
    end else begin
      cap_valid <= pop_alloc || pop_free;
      if (pop_alloc || pop_free) begin
        cap_src <= pop_free ? SRC_FREE : SRC_ALLOC;
        rr      <= other_src(pop_free ? SRC_FREE : SRC_ALLOC);
      end
    end
  end

  assign cap_is_free = (cap_src == SRC_FREE);
  assign cap_fail    = cap_is_free ? free_rsp_fail : alloc_rsp_fail;
  assign wr_data     = cap_is_free
      ? {1'b1, free_rsp_id, {PAGE_IDX_W{1'b0}}, free_rsp_fail, free_rsp_fail_reason}
      : {1'b0, alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason};

  rsp_showahead_fifo #(
    .W     (ENT_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cap_valid),
    .wr_data (wr_data),
    .rd_en   (rsp_ready),
    .rd_data (head),
    .count   (buf_count),
    .valid   (rsp_valid)
  );

  assign {rsp_is_free, rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason} = head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_alloc_ok   <= '0;
      stat_alloc_fail <= '0;
      stat_free_ok    <= '0;
      stat_free_fail  <= '0;
    end else if (cap_valid) begin
      unique case ({cap_is_free, cap_fail})
        2'b00: if (stat_alloc_ok   != STAT_MAX) stat_alloc_ok   <= stat_alloc_ok   + STAT_W'(1);
        2'b01: if (stat_alloc_fail != STAT_MAX) stat_alloc_fail <= stat_alloc_fail + STAT_W'(1);
        2'b10: if (stat_free_ok    != STAT_MAX) stat_free_ok    <= stat_free_ok    + STAT_W'(1);
        2'b11: if (stat_free_fail  != STAT_MAX) stat_free_fail  <= stat_free_fail  + STAT_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mmu_rsp_merger.sv
// Directed bench for mmu_rsp_merger with a pop/not_empty source model that mimics the mmu_top lag.
module tb_mmu_rsp_merger;
  typedef struct packed {
    logic        is_free;
    logic [12:0] id;
    logic [14:0] page;
    logic        fail;
    logic [2:0]  reason;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_ne = 1'b0, free_ne = 1'b0;
  logic        alloc_rsp_pop, free_rsp_pop;
  logic [12:0] alloc_rsp_id = '0, free_rsp_id = '0;
  logic [14:0] alloc_rsp_page_idx = '0;
  logic        alloc_rsp_fail = 1'b0, free_rsp_fail = 1'b0;
  logic [2:0]  alloc_rsp_fail_reason = '0, free_rsp_fail_reason = '0;
  logic        rsp_valid, rsp_is_free, rsp_fail;
  logic        rsp_ready = 1'b0;
  logic [12:0] rsp_id;
  logic [14:0] rsp_page_idx;
  logic [2:0]  rsp_fail_reason;
  logic [15:0] stat_alloc_ok, stat_alloc_fail, stat_free_ok, stat_free_fail;

  ent_t a_q[$], f_q[$], rx_q[$];
  int   pop_src[$], pop_cyc[$];
  int   cyc = 0, both_pops = 0, underflows = 0;
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;

  mmu_rsp_merger dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_rsp_fifo_not_empty(alloc_ne), .alloc_rsp_pop(alloc_rsp_pop),
    .alloc_rsp_id(alloc_rsp_id), .alloc_rsp_page_idx(alloc_rsp_page_idx),
    .alloc_rsp_fail(alloc_rsp_fail), .alloc_rsp_fail_reason(alloc_rsp_fail_reason),
    .free_rsp_fifo_not_empty(free_ne), .free_rsp_pop(free_rsp_pop),
    .free_rsp_id(free_rsp_id), .free_rsp_fail(free_rsp_fail),
    .free_rsp_fail_reason(free_rsp_fail_reason),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_free(rsp_is_free),
    .rsp_id(rsp_id), .rsp_page_idx(rsp_page_idx), .rsp_fail(rsp_fail),
    .rsp_fail_reason(rsp_fail_reason),
    .stat_alloc_ok(stat_alloc_ok), .stat_alloc_fail(stat_alloc_fail),
    .stat_free_ok(stat_free_ok), .stat_free_fail(stat_free_fail)
  );

  // Source FIFOs: not_empty reflects the pre-pop occupancy, data shows up the cycle after a pop.
  always @(posedge clk) begin : src_model
    ent_t e;
    alloc_ne <= (a_q.size() != 0);
    free_ne  <= (f_q.size() != 0);
    if (alloc_rsp_pop && a_q.size() != 0) begin
      e = a_q.pop_front();
      alloc_rsp_id <= e.id; alloc_rsp_page_idx <= e.page;
      alloc_rsp_fail <= e.fail; alloc_rsp_fail_reason <= e.reason;
    end else begin
      if (alloc_rsp_pop) underflows++;
      alloc_rsp_id <= 13'($urandom); alloc_rsp_page_idx <= 15'($urandom);
      alloc_rsp_fail <= 1'($urandom); alloc_rsp_fail_reason <= 3'($urandom);
    end
    if (free_rsp_pop && f_q.size() != 0) begin
      e = f_q.pop_front();
      free_rsp_id <= e.id; free_rsp_fail <= e.fail; free_rsp_fail_reason <= e.reason;
    end else begin
      if (free_rsp_pop) underflows++;
      free_rsp_id <= 13'($urandom); free_rsp_fail <= 1'($urandom);
      free_rsp_fail_reason <= 3'($urandom);
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (alloc_rsp_pop && free_rsp_pop) both_pops++;
    if (alloc_rsp_pop) begin pop_src.push_back(0); pop_cyc.push_back(cyc); end
    if (free_rsp_pop)  begin pop_src.push_back(1); pop_cyc.push_back(cyc); end
    if (rsp_valid && rsp_ready)
      rx_q.push_back({rsp_is_free, rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason});
  end

  function automatic ent_t mk(input logic fr, input logic [12:0] id, input logic [14:0] pg,
                              input logic fl, input logic [2:0] rs);
    mk = {fr, id, pg, fl, rs};
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin step(1); k++; end
    ok = (rx_q.size() >= n);
  endtask

  task automatic test_reset;
    int p0;
    rst_n = 1'b0; rsp_ready = 1'b1;
    a_q.push_back(mk(0, 13'h001, 15'h001, 0, 0));
    f_q.push_back(mk(1, 13'h002, 15'h000, 0, 0));
    step(1);
    p0 = pop_src.size();
    step(3);
    checks++; if (pop_src.size() != p0) begin errors++; $display("FAIL reset_pops got %0d want 0", pop_src.size() - p0); end
    checks++; if ({alloc_rsp_pop, free_rsp_pop} !== 2'b00) begin errors++; $display("FAIL reset_pop_now got %b want 00", {alloc_rsp_pop, free_rsp_pop}); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    checks++; if ({stat_alloc_ok, stat_alloc_fail, stat_free_ok, stat_free_fail} !== 64'h0) begin
      errors++; $display("FAIL reset_stats got %h %h %h %h want 0", stat_alloc_ok, stat_alloc_fail, stat_free_ok, stat_free_fail);
    end
    a_q.delete(); f_q.delete();
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_single_alloc;
    int k = 0;
    bit ok;
    rsp_ready = 1'b1;
    a_q.push_back(mk(0, 13'h0A5, 15'h1234, 0, 0));
    while (alloc_rsp_pop !== 1'b1 && k < 10) begin step(1); k++; end
    checks++; if (alloc_rsp_pop !== 1'b1) begin errors++; $display("FAIL single_pop got %b want 1 (timeout)", alloc_rsp_pop); end
    step(1);
    checks++; if (alloc_rsp_pop !== 1'b0) begin errors++; $display("FAIL single_pop_width got %b want 0", alloc_rsp_pop); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early got %b want 0", rsp_valid); end
    step(1);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid_lat2 got %b want 1", rsp_valid); end
    checks++; if ({rsp_is_free, rsp_id, rsp_page_idx, rsp_fail} !== {1'b0, 13'h0A5, 15'h1234, 1'b0}) begin
      errors++; $display("FAIL single_fields got free=%b id=%h page=%h fail=%b want 0 0a5 1234 0", rsp_is_free, rsp_id, rsp_page_idx, rsp_fail);
    end
    checks++; if (stat_alloc_ok !== 16'd1) begin errors++; $display("FAIL single_stat got %0d want 1", stat_alloc_ok); end
    step(1);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %b want 0", rsp_valid); end
    wait_rx(1, 1, ok);
  endtask

  task automatic test_round_robin;
    ent_t exp [6];
    int   b, r, n;
    bit   ok;
    rst_n = 1'b0; step(2); rst_n = 1'b1;
    rsp_ready = 1'b1;
    b = pop_src.size(); r = rx_q.size();
    exp[0] = mk(0, 13'h101, 15'h0011, 0, 0);
    exp[1] = mk(1, 13'h201, 15'h0000, 0, 0);
    exp[2] = mk(0, 13'h102, 15'h0022, 0, 0);
    exp[3] = mk(1, 13'h202, 15'h0000, 0, 0);
    exp[4] = mk(0, 13'h103, 15'h0033, 1, 3'd5);
    exp[5] = mk(1, 13'h203, 15'h0000, 0, 0);
    a_q.push_back(mk(0, 13'h101, 15'h0011, 0, 0));
    a_q.push_back(mk(0, 13'h102, 15'h0022, 0, 0));
    a_q.push_back(mk(0, 13'h103, 15'h0033, 1, 3'd5));
    for (int i = 0; i < 3; i++) f_q.push_back(mk(1, 13'(13'h201 + i), 15'h7FFF, 0, 0));
    wait_rx(r + 6, 40, ok);
    n = pop_src.size() - b;
    checks++; if (!ok || n != 6) begin errors++; $display("FAIL rr_count got pops=%0d rx=%0d want 6 6", n, rx_q.size() - r); end
    if (ok && n == 6) begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (pop_src[b + i] != i % 2) begin errors++; $display("FAIL rr_order[%0d] got %0d want %0d", i, pop_src[b + i], i % 2); end
        if (i > 0) begin
          checks++; if (pop_cyc[b + i] != pop_cyc[b + i - 1] + 1) begin
            errors++; $display("FAIL rr_b2b[%0d] got gap %0d want 1", i, pop_cyc[b + i] - pop_cyc[b + i - 1]);
          end
        end
        checks++; if (rx_q[r + i] !== exp[i]) begin errors++; $display("FAIL rr_rx[%0d] got %h want %h", i, rx_q[r + i], exp[i]); end
      end
    end
    step(2);
    checks++; if ({stat_alloc_ok, stat_alloc_fail, stat_free_ok, stat_free_fail} !== {16'd2, 16'd1, 16'd3, 16'd0}) begin
      errors++; $display("FAIL rr_stats got %0d %0d %0d %0d want 2 1 3 0", stat_alloc_ok, stat_alloc_fail, stat_free_ok, stat_free_fail);
    end
  endtask

  task automatic test_backpressure;
    int  b, r;
    bit  ok;
    rsp_ready = 1'b0;
    b = pop_src.size(); r = rx_q.size();
    for (int i = 0; i < 10; i++) a_q.push_back(mk(0, 13'(13'h300 + i), 15'(15'h400 + i), 0, 0));
    step(30);
    checks++; if (pop_src.size() - b != 4) begin errors++; $display("FAIL bp_pops got %0d want 4", pop_src.size() - b); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", rsp_valid); end
    rsp_ready = 1'b1;
    wait_rx(r + 10, 80, ok);
    step(3);
    checks++; if (!ok || rx_q.size() - r != 10 || pop_src.size() - b != 10) begin
      errors++; $display("FAIL bp_drain got rx=%0d pops=%0d want 10 10", rx_q.size() - r, pop_src.size() - b);
    end
    if (rx_q.size() - r == 10) begin
      for (int i = 0; i < 10; i++) begin
        checks++; if (rx_q[r + i] !== mk(0, 13'(13'h300 + i), 15'(15'h400 + i), 0, 0)) begin
          errors++; $display("FAIL bp_rx[%0d] got id=%h page=%h want %h %h", i, rx_q[r + i].id, rx_q[r + i].page, 13'(13'h300 + i), 15'(15'h400 + i));
        end
      end
    end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", rsp_valid); end
    checks++; if (stat_alloc_ok !== 16'd12) begin errors++; $display("FAIL bp_stat got %0d want 12", stat_alloc_ok); end
  endtask

  task automatic test_free_fail;
    int r;
    bit ok;
    rsp_ready = 1'b1;
    r = rx_q.size();
    f_q.push_back(mk(1, 13'h1EE, 15'h5555, 1, 3'd3));
    wait_rx(r + 1, 20, ok);
    step(1);
    checks++; if (!ok) begin errors++; $display("FAIL ff_timeout got rx=%0d want 1", rx_q.size() - r); end
    else begin
      checks++; if (rx_q[r] !== mk(1, 13'h1EE, 15'h0000, 1, 3'd3)) begin
        errors++; $display("FAIL ff_fields got free=%b id=%h page=%h fail=%b rsn=%0d want 1 1ee 0 1 3",
                           rx_q[r].is_free, rx_q[r].id, rx_q[r].page, rx_q[r].fail, rx_q[r].reason);
      end
    end
    checks++; if ({stat_free_ok, stat_free_fail} !== {16'd3, 16'd1}) begin
      errors++; $display("FAIL ff_stats got ok=%0d fail=%0d want 3 1", stat_free_ok, stat_free_fail);
    end
  endtask

  task automatic test_saturation;
    int r;
    bit ok;
    rsp_ready = 1'b1;
    force dut.stat_alloc_ok = 16'hFFFE;
    step(1);
    release dut.stat_alloc_ok;
    step(1);
    checks++; if (stat_alloc_ok !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got %h want fffe", stat_alloc_ok); end
    r = rx_q.size();
    for (int i = 0; i < 3; i++) a_q.push_back(mk(0, 13'(13'h500 + i), 15'h0001, 0, 0));
    wait_rx(r + 1, 20, ok);
    checks++; if (stat_alloc_ok !== 16'hFFFF) begin errors++; $display("FAIL sat_first got %h want ffff", stat_alloc_ok); end
    wait_rx(r + 3, 30, ok);
    step(2);
    checks++; if (!ok) begin errors++; $display("FAIL sat_timeout got rx=%0d want 3", rx_q.size() - r); end
    checks++; if (stat_alloc_ok !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", stat_alloc_ok); end
    checks++; if (stat_alloc_fail !== 16'd1) begin errors++; $display("FAIL sat_other got %0d want 1", stat_alloc_fail); end
  endtask

  task automatic test_reset_discard;
    int r, k = 0;
    rsp_ready = 1'b1;
    r = rx_q.size();
    a_q.push_back(mk(0, 13'h777, 15'h0777, 0, 0));
    while (alloc_rsp_pop !== 1'b1 && k < 10) begin step(1); k++; end
    checks++; if (alloc_rsp_pop !== 1'b1) begin errors++; $display("FAIL rd_pop got %b want 1 (timeout)", alloc_rsp_pop); end
    step(1);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(4);
    checks++; if (a_q.size() != 0) begin errors++; $display("FAIL rd_popped got %0d left want 0", a_q.size()); end
    checks++; if (rsp_valid !== 1'b0 || rx_q.size() != r) begin
      errors++; $display("FAIL rd_dropped got valid=%b rx=%0d want 0 0", rsp_valid, rx_q.size() - r);
    end
    checks++; if ({stat_alloc_ok, stat_alloc_fail, stat_free_ok, stat_free_fail} !== 64'h0) begin
      errors++; $display("FAIL rd_stats got %h %h %h %h want 0", stat_alloc_ok, stat_alloc_fail, stat_free_ok, stat_free_fail);
    end
  endtask

  task automatic test_protocol;
    checks++; if (both_pops != 0) begin errors++; $display("FAIL proto_dual_pop got %0d want 0", both_pops); end
    checks++; if (underflows != 0) begin errors++; $display("FAIL proto_underflow got %0d want 0", underflows); end
  endtask

  initial begin
    test_reset();
    test_single_alloc();
    test_round_robin();
    test_backpressure();
    test_free_fail();
    test_saturation();
    test_reset_discard();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got no finish want finish before 100000");
    $fatal(1);
  end
endmodule
